// File: rtl/ethernet_rx_bus_upsizer.sv
// ethernet_rx_bus_upsizer: packs a 32-bit EthernetRxBus into OUT_BYTES-wide words,
// forwarding frame control and counting committed/dropped frames.
module ethernet_rx_bus_upsizer #(
    parameter int OUT_BYTES = 8,
    localparam int BV_BITS = $clog2(OUT_BYTES) + 1,
    localparam int W = OUT_BYTES * 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_start,
    input  logic               in_data_valid,
    input  logic               in_commit,
    input  logic               in_drop,
    input  logic [2:0]         in_bytes_valid,
    input  logic [31:0]        in_data,
    output logic               out_start,
    output logic               out_data_valid,
    output logic               out_commit,
    output logic               out_drop,
    output logic [BV_BITS-1:0] out_bytes_valid,
    output logic [W-1:0]       out_data,
    output logic [31:0]        frames_committed,
    output logic [31:0]        frames_dropped
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [1:0] FLUSH  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [W-1:0]       buf_q, buf_d;
    logic [BV_BITS-1:0] cnt_q, cnt_d;
    logic               start_q, start_d, dv_q, dv_d, commit_q, commit_d, drop_q, drop_d;
    logic [BV_BITS-1:0] bv_q, bv_d;
    logic [W-1:0]       data_q, data_d;
    logic [31:0]        fc_q, fc_d, fd_q, fd_d;

    logic [2:0]         bv_eff;
    logic [31:0]        word_m;
    logic [W-1:0]       nb;
    logic [BV_BITS-1:0] nc;
    logic               take, last, emit;

    // Bytes past in_bytes_valid are masked so unused output bytes stay zero.
    assign bv_eff = (in_bytes_valid > 3'd4) ? 3'd4 : in_bytes_valid;
    assign word_m = in_data & (bv_eff == 3'd4 ? 32'hFFFF_FFFF :
                               bv_eff == 3'd3 ? 32'hFFFF_FF00 :
                               bv_eff == 3'd2 ? 32'hFFFF_0000 :
                               bv_eff == 3'd1 ? 32'hFF00_0000 : 32'h0);
    assign take = (state_q == ACTIVE) && in_data_valid;
    assign nb   = take ? (buf_q | ({word_m, {(W-32){1'b0}}} >> {cnt_q, 3'b000})) : buf_q;
    assign nc   = take ? cnt_q + BV_BITS'(bv_eff) : cnt_q;
    assign last = take && (bv_eff != 3'd4);
    assign emit = (nc == BV_BITS'(OUT_BYTES)) || last || (in_commit && nc != '0);

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        dv_d     = 1'b0;
        commit_d = 1'b0;
        drop_d   = 1'b0;
        bv_d     = '0;
        data_d   = '0;
        fc_d     = fc_q;
        fd_d     = fd_q;
        if (state_q == IDLE) begin
            if (in_start) begin
                start_d = 1'b1;
                buf_d   = '0;
                cnt_d   = '0;
                state_d = ACTIVE;
            end
        end else if (state_q == FLUSH) begin
            commit_d = 1'b1;
            fc_d     = fc_q + 32'd1;
            state_d  = IDLE;
        end else if (in_drop || in_start) begin
            drop_d  = 1'b1;
            fd_d    = fd_q + 32'd1;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end else begin
            buf_d = emit ? '0 : nb;
            cnt_d = emit ? '0 : nc;
            dv_d  = emit;
            bv_d  = emit ? nc : '0;
            data_d = emit ? nb : '0;
            if (last) state_d = DONE;
            // A commit that also emits data is deferred a cycle so the two pulses never overlap.
            if (in_commit) begin
                state_d  = emit ? FLUSH : IDLE;
                commit_d = !emit;
                fc_d     = emit ? fc_q : fc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            dv_q     <= 1'b0;
            commit_q <= 1'b0;
            drop_q   <= 1'b0;
            bv_q     <= '0;
            data_q   <= '0;
            fc_q     <= '0;
            fd_q     <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            dv_q     <= dv_d;
            commit_q <= commit_d;
            drop_q   <= drop_d;
            bv_q     <= bv_d;
            data_q   <= data_d;
            fc_q     <= fc_d;
            fd_q     <= fd_d;
        end
    end

    assign out_start        = start_q;
    assign out_data_valid   = dv_q;
    assign out_commit       = commit_q;
    assign out_drop         = drop_q;
    assign out_bytes_valid  = bv_q;
    assign out_data         = data_q;
    assign frames_committed = fc_q;
    assign frames_dropped   = fd_q;
endmodule

// File: tb/tb_ethernet_rx_bus_upsizer.sv
// tb_ethernet_rx_bus_upsizer: directed vector table for the 8-byte build plus
// hand-written 32-byte and reset sequences.
module tb_ethernet_rx_bus_upsizer;
    typedef struct {
        logic        s, dv, c, d;
        logic [2:0]  bv;
        logic [31:0] data;
        logic [3:0]  ectl;
        logic [3:0]  ebv;
        logic [63:0] edata;
        logic [31:0] efc, efd;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, s8, dv8, c8, d8;
    logic [2:0]  bv8;
    logic [31:0] data8;
    logic        os8, odv8, oc8, od8;
    logic [3:0]  obv8;
    logic [63:0] odata8;
    logic [31:0] fc8, fd8;

    logic        rst32_n, s32, dv32, c32, d32;
    logic [2:0]  bv32;
    logic [31:0] data32;
    logic        os32, odv32, oc32, od32;
    logic [5:0]  obv32;
    logic [255:0] odata32;
    logic [31:0] fc32, fd32;

    ethernet_rx_bus_upsizer #(.OUT_BYTES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_start(s8), .in_data_valid(dv8), .in_commit(c8),
        .in_drop(d8), .in_bytes_valid(bv8), .in_data(data8), .out_start(os8),
        .out_data_valid(odv8), .out_commit(oc8), .out_drop(od8), .out_bytes_valid(obv8),
        .out_data(odata8), .frames_committed(fc8), .frames_dropped(fd8));

    ethernet_rx_bus_upsizer #(.OUT_BYTES(32)) dut32 (
        .clk(clk), .rst_n(rst32_n), .in_start(s32), .in_data_valid(dv32), .in_commit(c32),
        .in_drop(d32), .in_bytes_valid(bv32), .in_data(data32), .out_start(os32),
        .out_data_valid(odv32), .out_commit(oc32), .out_drop(od32), .out_bytes_valid(obv32),
        .out_data(odata32), .frames_committed(fc32), .frames_dropped(fd32));

    int n_vec = 0, n_cmp = 0, n_miss = 0;
    vec_t tv[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, dv, c, d, input logic [2:0] bv, input logic [31:0] data,
                                input logic [3:0] ectl, input logic [3:0] ebv, input logic [63:0] edata,
                                input int efc, efd);
        vec_t v;
        v.s = s; v.dv = dv; v.c = c; v.d = d; v.bv = bv; v.data = data;
        v.ectl = ectl; v.ebv = ebv; v.edata = edata; v.efc = efc; v.efd = efd;
        return v;
    endfunction

    task automatic step32(input logic s, dv, c, input logic [31:0] data);
        @(negedge clk);
        s32 = s; dv32 = dv; c32 = c; d32 = 1'b0; bv32 = 3'd4; data32 = data;
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    initial begin
        logic [255:0] exp32;
        rst_n = 0; rst32_n = 0;
        {s8, dv8, c8, d8, bv8, data8} = '0;
        {s32, dv32, c32, d32, bv32, data32} = '0;
        // ectl order: {start, data_valid, commit, drop}
        tv.push_back(mk(1,0,0,0,0,0,            4'b1000,0,64'h0,0,0));
        tv.push_back(mk(0,1,0,0,4,32'h11223344, 4'b0000,0,64'h0,0,0));
        tv.push_back(mk(0,1,0,0,4,32'h55667788, 4'b0100,8,64'h1122334455667788,0,0));
        tv.push_back(mk(0,0,1,0,0,0,            4'b0010,0,64'h0,1,0));
        tv.push_back(mk(0,0,0,0,0,0,            4'b0000,0,64'h0,1,0));
        tv.push_back(mk(1,0,0,0,0,0,            4'b1000,0,64'h0,1,0));
        tv.push_back(mk(0,1,0,0,4,32'h01020304, 4'b0000,0,64'h0,1,0));
        tv.push_back(mk(0,1,0,0,4,32'h05060708, 4'b0100,8,64'h0102030405060708,1,0));
        tv.push_back(mk(0,1,0,0,2,32'h090A0000, 4'b0100,2,64'h090A000000000000,1,0));
        tv.push_back(mk(0,1,0,0,4,32'h11111111, 4'b0000,0,64'h0,1,0));
        tv.push_back(mk(0,0,1,0,0,0,            4'b0010,0,64'h0,2,0));
        tv.push_back(mk(1,0,0,0,0,0,            4'b1000,0,64'h0,2,0));
        tv.push_back(mk(0,1,0,0,4,32'h01020304, 4'b0000,0,64'h0,2,0));
        tv.push_back(mk(0,1,0,0,4,32'h05060708, 4'b0100,8,64'h0102030405060708,2,0));
        tv.push_back(mk(0,1,0,0,4,32'h0D0E0F10, 4'b0000,0,64'h0,2,0));
        tv.push_back(mk(0,0,1,0,0,0,            4'b0100,4,64'h0D0E0F1000000000,2,0));
        tv.push_back(mk(1,0,0,0,0,0,            4'b0010,0,64'h0,3,0));
        tv.push_back(mk(0,0,0,0,0,0,            4'b0000,0,64'h0,3,0));
        tv.push_back(mk(1,0,0,0,0,0,            4'b1000,0,64'h0,3,0));
        tv.push_back(mk(0,1,0,0,4,32'hAABBCCDD, 4'b0000,0,64'h0,3,0));
        tv.push_back(mk(0,0,0,1,0,0,            4'b0001,0,64'h0,3,1));
        tv.push_back(mk(1,0,0,0,0,0,            4'b1000,0,64'h0,3,1));
        tv.push_back(mk(0,1,0,0,4,32'h01010101, 4'b0000,0,64'h0,3,1));
        tv.push_back(mk(1,0,0,0,0,0,            4'b0001,0,64'h0,3,2));
        tv.push_back(mk(0,1,0,0,4,32'h02020202, 4'b0000,0,64'h0,3,2));
        tv.push_back(mk(0,1,0,0,4,32'h03030303, 4'b0000,0,64'h0,3,2));
        tv.push_back(mk(0,0,1,0,0,0,            4'b0000,0,64'h0,3,2));
        tv.push_back(mk(1,0,0,0,0,0,            4'b1000,0,64'h0,3,2));
        tv.push_back(mk(0,1,1,0,4,32'hCAFEBABE, 4'b0100,4,64'hCAFEBABE00000000,3,2));
        tv.push_back(mk(0,0,0,0,0,0,            4'b0010,0,64'h0,4,2));
        tv.push_back(mk(1,0,0,0,0,0,            4'b1000,0,64'h0,4,2));
        tv.push_back(mk(0,1,0,0,4,32'h12345678, 4'b0000,0,64'h0,4,2));
        tv.push_back(mk(0,1,1,1,4,32'h9ABCDEF0, 4'b0001,0,64'h0,4,3));
        tv.push_back(mk(1,0,0,0,0,0,            4'b1000,0,64'h0,4,3));
        tv.push_back(mk(0,1,0,0,4,32'h11111111, 4'b0000,0,64'h0,4,3));
        tv.push_back(mk(0,1,1,0,4,32'h22222222, 4'b0100,8,64'h1111111122222222,4,3));
        tv.push_back(mk(0,0,0,0,0,0,            4'b0010,0,64'h0,5,3));
        tv.push_back(mk(1,0,0,0,0,0,            4'b1000,0,64'h0,5,3));
        tv.push_back(mk(0,1,1,0,1,32'hABCDEF01, 4'b0100,1,64'hAB00000000000000,5,3));
        tv.push_back(mk(0,0,0,0,0,0,            4'b0010,0,64'h0,6,3));
        tv.push_back(mk(1,0,0,0,0,0,            4'b1000,0,64'h0,6,3));
        tv.push_back(mk(0,1,0,0,3,32'h12345678, 4'b0100,3,64'h1234560000000000,6,3));
        tv.push_back(mk(0,0,0,1,0,0,            4'b0001,0,64'h0,6,4));

        #12;
        chk("reset ctl8", {os8, odv8, oc8, od8}, 0);
        chk("reset data8", {obv8, odata8}, 0);
        chk("reset cnt8", {fc8, fd8}, 0);
        @(negedge clk);
        rst_n = 1; rst32_n = 1;

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            {s8, dv8, c8, d8, bv8, data8} = {tv[i].s, tv[i].dv, tv[i].c, tv[i].d, tv[i].bv, tv[i].data};
            @(posedge clk);
            #1;
            n_vec++;
            chk($sformatf("row%0d ctl", i), {os8, odv8, oc8, od8}, tv[i].ectl);
            chk($sformatf("row%0d bv", i), obv8, tv[i].ebv);
            chk($sformatf("row%0d data", i), odata8, tv[i].edata);
            chk($sformatf("row%0d committed", i), fc8, tv[i].efc);
            chk($sformatf("row%0d dropped", i), fd8, tv[i].efd);
        end

        step32(1, 0, 0, 0);
        chk("w32 start", {os32, odv32, oc32, od32}, 4'b1000);
        exp32 = '0;
        for (int i = 0; i < 8; i++) begin
            step32(0, 1, 0, 32'h01010101 * (i + 1));
            exp32 = {exp32[223:0], 32'h01010101 * (i + 1)};
            if (i < 7) chk($sformatf("w32 word%0d idle", i), {os32, odv32, oc32, od32}, 0);
        end
        chk("w32 dv", {os32, odv32, oc32, od32}, 4'b0100);
        chk("w32 bv", obv32, 32);
        chk("w32 data", odata32, exp32);
        step32(0, 0, 1, 0);
        chk("w32 commit", {os32, odv32, oc32, od32, fc32}, {4'b0010, 32'd1});

        step32(1, 0, 0, 0);
        step32(0, 1, 0, 32'hDEADBEEF);
        step32(0, 1, 0, 32'hFEEDFACE);
        #2;
        rst32_n = 0;
        #1;
        chk("rst32 ctl", {os32, odv32, oc32, od32}, 0);
        chk("rst32 data", {obv32, odata32}, 0);
        chk("rst32 counters", {fc32, fd32}, 0);
        @(negedge clk);
        rst32_n = 1;
        step32(0, 0, 1, 0);
        chk("post-rst stray commit", {os32, odv32, oc32, od32, fc32, fd32}, 0);
        step32(1, 0, 0, 0);
        chk("post-rst start", {os32, odv32, oc32, od32}, 4'b1000);
        exp32 = '0;
        for (int i = 0; i < 8; i++) begin
            step32(0, 1, 0, 32'h11111111 * (i + 1));
            exp32 = {exp32[223:0], 32'h11111111 * (i + 1)};
        end
        chk("post-rst dv", {os32, odv32, oc32, od32, obv32}, {4'b0100, 6'd32});
        chk("post-rst data", odata32, exp32);
        step32(0, 0, 1, 0);
        chk("post-rst commit", {os32, odv32, oc32, od32, fc32, fd32}, {4'b0010, 32'd1, 32'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/ethernet_rx_bus_upsizer.md
ETHERNET_RX_BUS_UPSIZER -- requirements
Module: ethernet_rx_bus_upsizer

Interface
REQ-001 Parameter OUT_BYTES, default 8, output word width in bytes; legal values 8, 16, 32.
REQ-002 Derived BV_BITS = $clog2(OUT_BYTES)+1, width of out_bytes_valid.
REQ-003 clk  input  1  single clock; all logic in this domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_start, in_data_valid, in_commit, in_drop  input  1 each  EthernetRxBus control fields, same semantics as the package.
REQ-006 in_bytes_valid  input  3  valid bytes, left-aligned, 1..4.
REQ-007 in_data  input  32  payload, first byte in [31:24].
REQ-008 out_start, out_data_valid, out_commit, out_drop  output  1 each  widened-bus control, same conventions as EthernetRxBus.
REQ-009 out_bytes_valid  output  BV_BITS  valid bytes, left-aligned, 1..OUT_BYTES.
REQ-010 out_data  output  OUT_BYTES*8  payload, first byte in MSB.
REQ-011 frames_committed, frames_dropped  output  32 each  frame counters.

Function
REQ-012 All outputs shall be registered; control outputs shall be single-cycle pulses.
REQ-013 FSM states: IDLE, ACTIVE, DONE (last partial word seen), FLUSH (commit pending behind a flush).
REQ-014 IDLE: in_start -> out_start at T+1, buffer cleared, state ACTIVE; data, commit, drop ignored.
REQ-015 ACTIVE: each in_data_valid word is packed into the buffer at the next left-aligned 4-byte slot.
REQ-016 When the buffer holds OUT_BYTES valid bytes, out_data_valid shall pulse at T+1 (T = completing input cycle), out_bytes_valid = OUT_BYTES, buffer cleared.
REQ-017 Input word with in_bytes_valid < 4 is the last word: buffer emitted at T+1 with out_bytes_valid = accumulated bytes, state DONE.
REQ-018 Unused out_data bytes shall be zero.
REQ-019 DONE: further in_data_valid words ignored until commit or drop.
REQ-020 in_commit with empty buffer -> out_commit at T+1, frames_committed += 1, state IDLE.
REQ-021 in_commit with non-empty buffer -> flush buffer at T+1 (out_data_valid, partial count), out_commit at T+2, state FLUSH for one cycle, then IDLE; inputs ignored in FLUSH.
REQ-022 in_commit with simultaneous in_data_valid: data packed first, then REQ-020/021 applied to resulting buffer.
REQ-023 in_drop in ACTIVE or DONE -> buffer discarded, no data output, out_drop at T+1, frames_dropped += 1, state IDLE.
REQ-024 in_drop wins over simultaneous in_data_valid or in_commit.
REQ-025 in_start in ACTIVE or DONE -> treated as drop (REQ-023); no out_start; subsequent frame ignored until next in_start seen in IDLE.
REQ-026 Counters wrap modulo 2^32 with no saturation.
REQ-027 out_data_valid shall never coincide with out_start, out_commit or out_drop.

Reset
REQ-028 rst_n low shall immediately clear all outputs, counters and buffer to 0 and force IDLE.
REQ-029 Reset mid-frame shall discard the frame with no out_drop or out_commit; first in_start after release starts a clean frame.

Verification (OUT_BYTES=8 unless noted)
REQ-030 start@0, 0x11223344@1, 0x55667788@2, commit@3 -> out_start@1, out_data 0x1122334455667788 bv=8 @3, out_commit@4, frames_committed=1.
REQ-031 Words 0x01020304, 0x05060708, 0x090A0000 bv=2, then commit -> 0x0102030405060708 bv=8, then 0x090A000000000000 bv=2, then out_commit one cycle after commit.
REQ-032 Three full words, commit@T -> third word flushed as 0x0D0E0F1000000000 bv=4 @T+1, out_commit @T+2.
REQ-033 start, one word, drop -> out_drop one cycle after drop, no out_data_valid, frames_dropped=1.
REQ-034 start, one word, second in_start, two words, commit -> out_drop only; no out_data_valid or out_commit; counters 0/1.
REQ-035 OUT_BYTES=32, 8 full words then commit -> single 256-bit word bv=32, out_commit next cycle; rst_n pulse mid-frame -> outputs 0, next frame passes clean.
